// File: rtl/cpu_types_pkg.sv
// Shared CPU types and constants.
//   CPU_WORD_W / CPU_REG_AW : default datapath and register-file address widths
//   word_t, regbits_t       : datapath word and register index
//   memstate_t              : memory-stage request state (idle, waiting on dhit, halted)
package cpu_types_pkg;

    localparam int CPU_WORD_W = 32;
    localparam int CPU_REG_AW = 5;

    typedef logic [CPU_WORD_W-1:0] word_t;
    typedef logic [CPU_REG_AW-1:0] regbits_t;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_HALTED
    } memstate_t;

endpackage

// File: rtl/branch_resolve.sv
// Combinational control-flow resolver.
//   Branch_i, BNE_i, zero_i : conditional branch, bne sense, ALU zero flag
//   jump_i, jr_i            : j/jal and jr
//   npc_i                   : fall-through PC, driven on redirect_pc when nothing is taken
//   rdat1_i                 : jr target
//   target_i                : j/jal target
//   br_target_i             : branch target
//   redirect, redirect_pc   : redirect request and its PC
// Any gating (stalls, halt) is left to the instantiating stage.
module branch_resolve #(
    parameter int WORD_W = 32
) (
    input  logic              Branch_i,
    input  logic              BNE_i,
    input  logic              zero_i,
    input  logic              jump_i,
    input  logic              jr_i,
    input  logic [WORD_W-1:0] npc_i,
    input  logic [WORD_W-1:0] rdat1_i,
    input  logic [WORD_W-1:0] target_i,
    input  logic [WORD_W-1:0] br_target_i,
    output logic              redirect,
    output logic [WORD_W-1:0] redirect_pc
);

    logic taken;

    // beq takes on zero, bne on non-zero
    assign taken    = Branch_i & (zero_i ^ BNE_i);
    assign redirect = taken | jump_i | jr_i;

    always_comb begin
        if (jr_i)
            redirect_pc = rdat1_i;
        else if (jump_i)
            redirect_pc = target_i;
        else if (taken)
            redirect_pc = br_target_i;
        else
            redirect_pc = npc_i;
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline latch.
//   CLK, nRST                  : clock, asynchronous active-low reset
//   *_i                        : EX/MEM latch outputs (held stable while mem_stall)
//   dhit, dmemload             : cache completion and load data
//   dmemREN/WEN/addr/store     : cache request
//   mem_stall                  : hold upstream latches this cycle
//   redirect, redirect_pc      : PC redirect for branch/jump/jr
//   wb_wdat/wb_wsel/wb_WEN     : registered writeback
//   wb_halt                    : registered sticky halt
module mem_wb_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = CPU_WORD_W,
    parameter int REG_AW = CPU_REG_AW
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] npc_i,
    input  logic [WORD_W-1:0] alu_out_i,
    input  logic [WORD_W-1:0] rdat1_i,
    input  logic [WORD_W-1:0] rdat2_i,
    input  logic [WORD_W-1:0] br_target_i,
    input  logic [WORD_W-1:0] target_i,
    input  logic              DRen_i,
    input  logic              DWen_i,
    input  logic              dload_i,
    input  logic              jal_i,
    input  logic              RegW_i,
    input  logic [REG_AW-1:0] RegDest_i,
    input  logic              Branch_i,
    input  logic              BNE_i,
    input  logic              zero_i,
    input  logic              jump_i,
    input  logic              jr_i,
    input  logic              halt_i,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              redirect,
    output logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] wb_wdat,
    output logic [REG_AW-1:0] wb_wsel,
    output logic              wb_WEN,
    output logic              wb_halt
);

    memstate_t         state;
    logic              halted;
    logic              active;
    logic              acc;
    logic              br_redirect;
    logic [WORD_W-1:0] br_pc;

    assign halted = (state == MEM_HALTED);
    // Combinational outputs are forced low during reset as well as once halted
    assign active = nRST & ~halted;
    assign acc    = DRen_i | DWen_i;

    // Write wins when both read and write are requested
    assign dmemWEN   = active & DWen_i;
    assign dmemREN   = active & DRen_i & ~DWen_i;
    assign dmemaddr  = active ? alu_out_i : '0;
    assign dmemstore = active ? rdat2_i : '0;

    // dhit with no access outstanding has no effect
    assign mem_stall = active & acc & ~dhit;

    branch_resolve #(
        .WORD_W (WORD_W)
    ) u_branch_resolve (
        .Branch_i    (Branch_i),
        .BNE_i       (BNE_i),
        .zero_i      (zero_i),
        .jump_i      (jump_i),
        .jr_i        (jr_i),
        .npc_i       (npc_i),
        .rdat1_i     (rdat1_i),
        .target_i    (target_i),
        .br_target_i (br_target_i),
        .redirect    (br_redirect),
        .redirect_pc (br_pc)
    );

    // A redirect must not fire while the instruction is still stuck in MEM
    assign redirect    = active & ~mem_stall & br_redirect;
    assign redirect_pc = nRST ? br_pc : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= MEM_IDLE;
            wb_wdat <= '0;
            wb_wsel <= '0;
            wb_WEN  <= 1'b0;
            wb_halt <= 1'b0;
        end else begin
            case (state)
                MEM_HALTED: begin
                    // Terminal until reset; wb_halt stays set
                    wb_WEN <= 1'b0;
                end
                default: begin
                    if (mem_stall) begin
                        // Bubble: data and destination hold, write enable drops
                        state  <= MEM_WAIT;
                        wb_WEN <= 1'b0;
                    end else begin
                        // Zero-wait completion, completion out of WAIT, or no access
                        state   <= halt_i ? MEM_HALTED : MEM_IDLE;
                        wb_wdat <= dload_i ? dmemload : (jal_i ? npc_i : alu_out_i);
                        wb_wsel <= RegDest_i;
                        wb_WEN  <= RegW_i & (RegDest_i != '0);
                        wb_halt <= wb_halt | halt_i;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] npc_i, alu_out_i, rdat1_i, rdat2_i, br_target_i, target_i;
    logic        DRen_i, DWen_i, dload_i, jal_i, RegW_i;
    logic [4:0]  RegDest_i;
    logic        Branch_i, BNE_i, zero_i, jump_i, jr_i, halt_i;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN, mem_stall, redirect, wb_WEN, wb_halt;
    logic [31:0] dmemaddr, dmemstore, redirect_pc, wb_wdat;
    logic [4:0]  wb_wsel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural view of the MEM/WB latch
    logic [31:0] m_wdat;
    logic [4:0]  m_wsel;
    logic        m_wen, m_halt;

    // Expected combinational outputs for the current inputs
    logic        e_ren, e_wen, e_stall, e_redir, e_acc;
    logic [31:0] e_rpc;

    mem_wb_stage dut (
        .CLK(CLK), .nRST(nRST),
        .npc_i(npc_i), .alu_out_i(alu_out_i), .rdat1_i(rdat1_i), .rdat2_i(rdat2_i),
        .br_target_i(br_target_i), .target_i(target_i),
        .DRen_i(DRen_i), .DWen_i(DWen_i), .dload_i(dload_i), .jal_i(jal_i),
        .RegW_i(RegW_i), .RegDest_i(RegDest_i),
        .Branch_i(Branch_i), .BNE_i(BNE_i), .zero_i(zero_i), .jump_i(jump_i),
        .jr_i(jr_i), .halt_i(halt_i), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .wb_wdat(wb_wdat), .wb_wsel(wb_wsel), .wb_WEN(wb_WEN), .wb_halt(wb_halt)
    );

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        npc_i = 0; alu_out_i = 0; rdat1_i = 0; rdat2_i = 0; br_target_i = 0; target_i = 0;
        DRen_i = 0; DWen_i = 0; dload_i = 0; jal_i = 0; RegW_i = 0; RegDest_i = 0;
        Branch_i = 0; BNE_i = 0; zero_i = 0; jump_i = 0; jr_i = 0; halt_i = 0;
        dhit = 0; dmemload = 0;
    endtask

    // Expected outputs straight from the stage's rules
    task automatic calc_exp();
        logic live, taken;
        live    = nRST && !m_halt;
        e_acc   = DRen_i || DWen_i;
        e_wen   = live && DWen_i;
        e_ren   = live && DRen_i && !DWen_i;
        e_stall = live && e_acc && !dhit;
        taken   = Branch_i && (zero_i != BNE_i);
        e_redir = live && !e_stall && (taken || jump_i || jr_i);
        e_rpc   = jr_i ? rdat1_i : (jump_i ? target_i : br_target_i);
    endtask

    // Advance the model by one rising edge using the inputs currently applied
    task automatic model_edge();
        calc_exp();
        if (!nRST) begin
            m_wdat = 0; m_wsel = 0; m_wen = 0; m_halt = 0;
        end else if (m_halt || e_stall) begin
            m_wen = 0;
        end else begin
            m_wdat = dload_i ? dmemload : (jal_i ? npc_i : alu_out_i);
            m_wsel = RegDest_i;
            m_wen  = RegW_i && (RegDest_i != 0);
            m_halt = m_halt || halt_i;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
        calc_exp();
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 0;
        DRen_i = 1; alu_out_i = 32'h44;
        model_edge();
        settle();
        n_checks++; if (dmemREN !== 1'b0) begin n_fail++; $display("FAIL reset_ren got=%b exp=0", dmemREN); end
        n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
        @(posedge CLK); #1;
        n_checks++; if ({wb_wdat, wb_wsel, wb_WEN, wb_halt} !== 39'd0)
            begin n_fail++; $display("FAIL reset_wb got=%h/%0d/%b/%b exp=0/0/0/0", wb_wdat, wb_wsel, wb_WEN, wb_halt); end
        nRST = 1;
        clear_inputs();
        $display("reset released");
    endtask

    task automatic test_reset_in_wait();
        DRen_i = 1; dload_i = 1; RegW_i = 1; RegDest_i = 5; alu_out_i = 32'h100; dhit = 0;
        settle();
        n_checks++; if (dmemREN !== 1'b1 || mem_stall !== 1'b1)
            begin n_fail++; $display("FAIL rw_req got ren=%b stall=%b exp 1/1", dmemREN, mem_stall); end
        tick();
        nRST = 0;
        settle();
        n_checks++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0)
            begin n_fail++; $display("FAIL rw_drop got ren=%b stall=%b exp 0/0", dmemREN, mem_stall); end
        tick();
        n_checks++; if (wb_WEN !== 1'b0) begin n_fail++; $display("FAIL rw_wen got=%b exp=0", wb_WEN); end
        nRST = 1;
        clear_inputs();
        // Back in IDLE: a fresh access that hits completes with no stall
        DRen_i = 1; dload_i = 1; RegW_i = 1; RegDest_i = 6; alu_out_i = 32'h104;
        dhit = 1; dmemload = 32'h0BAD_F00D;
        settle();
        n_checks++; if (mem_stall !== 1'b0 || dmemaddr !== 32'h104)
            begin n_fail++; $display("FAIL rw_idle got stall=%b addr=%h exp 0/104", mem_stall, dmemaddr); end
        tick();
        n_checks++; if (wb_wdat !== 32'h0BAD_F00D || wb_WEN !== 1'b1)
            begin n_fail++; $display("FAIL rw_after got=%h/%b exp=0badf00d/1", wb_wdat, wb_WEN); end
        $display("reset-in-wait: wb_wdat=%h", wb_wdat);
        clear_inputs();
        tick();
    endtask

    task automatic test_load_miss();
        logic [2:0] exp_stall;
        exp_stall = 3'b110;
        DRen_i = 1; dload_i = 1; RegW_i = 1; RegDest_i = 8; alu_out_i = 32'h200;
        for (int c = 0; c < 3; c++) begin
            dhit = (c == 2);
            dmemload = (c == 2) ? 32'hDEAD_BEEF : 32'h0;
            settle();
            n_checks++; if (mem_stall !== exp_stall[2-c])
                begin n_fail++; $display("FAIL lm_stall%0d got=%b exp=%b", c, mem_stall, exp_stall[2-c]); end
            tick();
            if (c < 2) begin
                n_checks++; if (wb_WEN !== 1'b0) begin n_fail++; $display("FAIL lm_bubble%0d got=%b exp=0", c, wb_WEN); end
            end
        end
        n_checks++; if (wb_wdat !== 32'hDEAD_BEEF || wb_wsel !== 5'd8 || wb_WEN !== 1'b1)
            begin n_fail++; $display("FAIL lm_wb got=%h/%0d/%b exp=deadbeef/8/1", wb_wdat, wb_wsel, wb_WEN); end
        $display("load miss: wb_wdat=%h wsel=%0d", wb_wdat, wb_wsel);
        clear_inputs();
    endtask

    task automatic test_store_hit();
        DWen_i = 1; alu_out_i = 32'h40; rdat2_i = 32'h1234; dhit = 1;
        settle();
        n_checks++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemaddr !== 32'h40 || dmemstore !== 32'h1234 || mem_stall !== 1'b0)
            begin n_fail++; $display("FAIL st_req got wen=%b ren=%b addr=%h data=%h stall=%b exp 1/0/40/1234/0",
                  dmemWEN, dmemREN, dmemaddr, dmemstore, mem_stall); end
        tick();
        n_checks++; if (wb_WEN !== 1'b0) begin n_fail++; $display("FAIL st_wen got=%b exp=0", wb_WEN); end
        $display("store hit: addr=40 data=1234");
        // Read and write together: write wins
        DRen_i = 1; DWen_i = 1; dhit = 1;
        settle();
        n_checks++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0)
            begin n_fail++; $display("FAIL st_both got wen=%b ren=%b exp 1/0", dmemWEN, dmemREN); end
        tick();
        clear_inputs();
    endtask

    task automatic test_branches();
        Branch_i = 1; zero_i = 1; br_target_i = 32'h80; npc_i = 32'h24;
        settle();
        n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h80)
            begin n_fail++; $display("FAIL beq_taken got=%b/%h exp=1/80", redirect, redirect_pc); end
        BNE_i = 1;
        settle();
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL bne_nt got=%b exp=0", redirect); end
        clear_inputs();
        jr_i = 1; jump_i = 1; rdat1_i = 32'h3C; target_i = 32'h999;
        settle();
        n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h3C)
            begin n_fail++; $display("FAIL jr_prio got=%b/%h exp=1/3c", redirect, redirect_pc); end
        // Branch sitting behind a stalled load must not redirect yet
        clear_inputs();
        Branch_i = 1; zero_i = 1; br_target_i = 32'h80; DRen_i = 1; dhit = 0;
        settle();
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL br_stalled got=%b exp=0", redirect); end
        dhit = 1;
        settle();
        n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL br_released got=%b exp=1", redirect); end
        tick();
        $display("branches resolved");
        clear_inputs();
    endtask

    task automatic test_jal();
        jump_i = 1; jal_i = 1; RegW_i = 1; RegDest_i = 31; npc_i = 32'h10; target_i = 32'h400;
        alu_out_i = 32'h7777;
        settle();
        n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h400)
            begin n_fail++; $display("FAIL jal_redir got=%b/%h exp=1/400", redirect, redirect_pc); end
        tick();
        n_checks++; if (wb_wdat !== 32'h10 || wb_wsel !== 5'd31 || wb_WEN !== 1'b1)
            begin n_fail++; $display("FAIL jal_wb got=%h/%0d/%b exp=10/31/1", wb_wdat, wb_wsel, wb_WEN); end
        $display("jal: link=%h", wb_wdat);
        clear_inputs();
        RegW_i = 1; RegDest_i = 0; alu_out_i = 32'h55;
        tick();
        n_checks++; if (wb_WEN !== 1'b0) begin n_fail++; $display("FAIL r0_suppress got=%b exp=0", wb_WEN); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        DRen_i = 1; dload_i = 1; RegW_i = 1; RegDest_i = 3; alu_out_i = 32'h300;
        dhit = 1; dmemload = 32'hA5A5_0001;
        tick();
        // Next access appears immediately after the completion edge
        RegDest_i = 4; alu_out_i = 32'h304; dhit = 0; dmemload = 0;
        settle();
        n_checks++; if (dmemREN !== 1'b1 || dmemaddr !== 32'h304 || mem_stall !== 1'b1)
            begin n_fail++; $display("FAIL b2b_issue got ren=%b addr=%h stall=%b exp 1/304/1", dmemREN, dmemaddr, mem_stall); end
        n_checks++; if (wb_wdat !== 32'hA5A5_0001 || wb_wsel !== 5'd3)
            begin n_fail++; $display("FAIL b2b_first got=%h/%0d exp=a5a50001/3", wb_wdat, wb_wsel); end
        tick();
        dhit = 1; dmemload = 32'hA5A5_0002;
        tick();
        n_checks++; if (wb_wdat !== 32'hA5A5_0002 || wb_wsel !== 5'd4 || wb_WEN !== 1'b1)
            begin n_fail++; $display("FAIL b2b_second got=%h/%0d/%b exp=a5a50002/4/1", wb_wdat, wb_wsel, wb_WEN); end
        $display("back-to-back: %h then %h", 32'hA5A5_0001, wb_wdat);
        clear_inputs();
    endtask

    task automatic test_random();
        logic prev_stall;
        prev_stall = 0;
        for (int i = 0; i < 300; i++) begin
            if (!prev_stall) begin
                npc_i = $urandom; alu_out_i = $urandom; rdat1_i = $urandom; rdat2_i = $urandom;
                br_target_i = $urandom; target_i = $urandom;
                DRen_i = ($urandom_range(0, 2) == 0); DWen_i = ($urandom_range(0, 3) == 0);
                dload_i = $urandom; jal_i = $urandom; RegW_i = $urandom;
                RegDest_i = $urandom_range(0, 31);
                Branch_i = $urandom; BNE_i = $urandom; zero_i = $urandom;
                jump_i = ($urandom_range(0, 3) == 0); jr_i = ($urandom_range(0, 5) == 0);
                halt_i = 0;
            end
            dhit = $urandom; dmemload = $urandom;
            settle();
            n_checks++; if (dmemREN !== e_ren || dmemWEN !== e_wen || mem_stall !== e_stall || redirect !== e_redir)
                begin n_fail++; $display("FAIL rnd_ctl%0d got ren=%b wen=%b stall=%b redir=%b exp %b/%b/%b/%b",
                      i, dmemREN, dmemWEN, mem_stall, redirect, e_ren, e_wen, e_stall, e_redir); end
            if (e_acc) begin
                n_checks++; if (dmemaddr !== alu_out_i || dmemstore !== rdat2_i)
                    begin n_fail++; $display("FAIL rnd_addr%0d got=%h/%h exp=%h/%h", i, dmemaddr, dmemstore, alu_out_i, rdat2_i); end
            end
            if (e_redir) begin
                n_checks++; if (redirect_pc !== e_rpc)
                    begin n_fail++; $display("FAIL rnd_pc%0d got=%h exp=%h", i, redirect_pc, e_rpc); end
            end
            prev_stall = e_stall;
            tick();
            n_checks++; if (wb_WEN !== m_wen || wb_halt !== m_halt || (m_wen && (wb_wdat !== m_wdat || wb_wsel !== m_wsel)))
                begin n_fail++; $display("FAIL rnd_wb%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b",
                      i, wb_wdat, wb_wsel, wb_WEN, wb_halt, m_wdat, m_wsel, m_wen, m_halt); end
            if (m_wen) $display("rnd %0d: wb r%0d <= %h", i, wb_wsel, wb_wdat);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_halt();
        halt_i = 1; DRen_i = 1; alu_out_i = 32'h500; dhit = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++; if (wb_halt !== 1'b0) begin n_fail++; $display("FAIL halt_early%0d got=%b exp=0", c, wb_halt); end
        end
        dhit = 1;
        tick();
        n_checks++; if (wb_halt !== 1'b1) begin n_fail++; $display("FAIL halt_latch got=%b exp=1", wb_halt); end
        clear_inputs();
        DRen_i = 1; RegW_i = 1; RegDest_i = 9; Branch_i = 1; zero_i = 1; dhit = 0;
        settle();
        n_checks++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0 || redirect !== 1'b0)
            begin n_fail++; $display("FAIL halted_out got ren=%b stall=%b redir=%b exp 0/0/0", dmemREN, mem_stall, redirect); end
        tick();
        n_checks++; if (wb_halt !== 1'b1 || wb_WEN !== 1'b0)
            begin n_fail++; $display("FAIL halted_wb got halt=%b wen=%b exp 1/0", wb_halt, wb_WEN); end
        $display("halt: wb_halt=%b", wb_halt);
        clear_inputs();
    endtask

    initial begin
        m_wdat = 0; m_wsel = 0; m_wen = 0; m_halt = 0;
        test_reset();
        test_reset_in_wait();
        test_load_miss();
        test_store_hit();
        test_branches();
        test_jal();
        test_back_to_back();
        test_random();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
